// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the execute unit: ALU op codes, funct fields,
// B-operand select values and the mul/div engine state type.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, with sign fixup into HI/LO.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand_b, raw_a;
  logic             is_div, neg_q, neg_r, div_zero;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] product;

  // op[0] clear means a signed operation; op[1] set means divide
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign busy = (state != MD_IDLE);
  assign done = (state == MD_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_CALC;
      MD_CALC: if (count == '0) state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // acc_hi doubles as partial product high half / partial remainder,
  // acc_lo as multiplier / dividend-shifting-into-quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand_b};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {step_hi, step_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    product = {step_hi, step_lo};
    if (is_div) begin
      if (div_zero) begin
        fix_lo = '1;
        fix_hi = raw_a;
      end else begin
        fix_lo = neg_q ? -step_lo : step_lo;
        fix_hi = neg_r ? -step_hi : step_hi;
      end
    end else begin
      {fix_hi, fix_lo} = neg_q ? -product : product;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      raw_a     <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          acc_hi    <= '0;
          acc_lo    <= a_mag;
          operand_b <= b_mag;
          raw_a     <= a;
          is_div    <= op[1];
          neg_q     <= a_neg ^ b_neg;
          neg_r     <= a_neg;
          div_zero  <= (b == '0);
          count     <= CW'(WIDTH - 1);
        end
        MD_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (count == '0) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute unit: operand muxes, single-cycle ALU, registered alu_out and an
// iterative mul/div engine. Define ALU_OVERFLOW_EN for signed add/sub overflow.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic             alu_src_a,
  input  logic [1:0]       alu_src_b,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [IMM_W-1:0] imm,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow
);

  logic [WIDTH-1:0] a_val, b_val, imm_ext;
  logic             md_start;

  assign imm_ext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign a_val   = alu_src_a ? reg_a : pc;

  always_comb begin
    b_val = reg_b;
    case (alu_src_b)
      SRCB_REG:     b_val = reg_b;
      SRCB_FOUR:    b_val = WIDTH'(4);
      SRCB_IMM:     b_val = imm_ext;
      SRCB_IMM_SH2: b_val = {imm_ext[WIDTH-3:0], 2'b00};
      default:      b_val = reg_b;
    endcase
  end

  always_comb begin
    result = '0;
    case (alu_op)
      ALUOP_ADD: result = a_val + b_val;
      ALUOP_SUB: result = a_val - b_val;
      ALUOP_SLT: result = {{(WIDTH-1){1'b0}}, $signed(a_val) < $signed(b_val)};
      default: begin
        case (funct)
          FN_ADD:  result = a_val + b_val;
          FN_SUB:  result = a_val - b_val;
          FN_AND:  result = a_val & b_val;
          FN_OR:   result = a_val | b_val;
          FN_NOR:  result = ~(a_val | b_val);
          FN_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a_val) < $signed(b_val)};
          FN_SLTU: result = {{(WIDTH-1){1'b0}}, a_val < b_val};
          FN_MFHI: result = hi;
          FN_MFLO: result = lo;
          default: result = '0;
        endcase
      end
    endcase
  end

  assign zero = (result == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alu_out <= '0;
    else     alu_out <= result;
  end

  // The engine itself refuses a launch outside IDLE; here we only qualify the opcode
  assign md_start = start && (alu_op == ALUOP_FUNCT) &&
                    ((funct == FN_MULT) || (funct == FN_MULTU) ||
                     (funct == FN_DIV)  || (funct == FN_DIVU));

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (funct[1:0]),
    .a     (reg_a),
    .b     (reg_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

`ifdef ALU_OVERFLOW_EN
  logic is_add, is_sub;
  assign is_add = (alu_op == ALUOP_ADD) || ((alu_op == ALUOP_FUNCT) && (funct == FN_ADD));
  assign is_sub = (alu_op == ALUOP_SUB) || ((alu_op == ALUOP_FUNCT) && (funct == FN_SUB));

  always_comb begin
    overflow = 1'b0;
    if (is_add)
      overflow = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (result[WIDTH-1] != a_val[WIDTH-1]);
    else if (is_sub)
      overflow = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (result[WIDTH-1] != a_val[WIDTH-1]);
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: ALU decode/mux checks plus a scoreboard of
// expected HI/LO results popped when the mul/div engine pulses done.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int IMM_W = 16;

  logic             clk, rst;
  logic [1:0]       alu_op;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [5:0]       funct;
  logic [WIDTH-1:0] pc, reg_a, reg_b;
  logic [IMM_W-1:0] imm;
  logic             start;
  logic [WIDTH-1:0] result, alu_out, hi, lo;
  logic             zero, busy, done, overflow;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } md_exp_t;

  md_exp_t sb[$];
  int cmp_count = 0;
  int err_count = 0;
  logic exp_ovf;

  alu_muldiv #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .funct(funct), .pc(pc), .reg_a(reg_a),
    .reg_b(reg_b), .imm(imm), .start(start), .result(result),
    .alu_out(alu_out), .zero(zero), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    cmp_count++;
    assert (observed === expected)
    else begin
      err_count++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic src_a, input logic [1:0] src_b,
                               input logic [5:0] fn, input logic [WIDTH-1:0] pc_v,
                               input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                               input logic [IMM_W-1:0] imm_v, input logic start_v);
    alu_op    = op;
    alu_src_a = src_a;
    alu_src_b = src_b;
    funct     = fn;
    pc        = pc_v;
    reg_a     = a_v;
    reg_b     = b_v;
    imm       = imm_v;
    start     = start_v;
  endtask

  // Launch a mul/div, optionally poke a second start mid-CALC, and check that
  // done appears on the (WIDTH+1)th edge counting the edge that sampled start.
  task automatic runMulDiv(input string tag, input logic [5:0] fn,
                           input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                           input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo,
                           input bit intrude);
    md_exp_t e;
    md_exp_t got;
    int edges;
    int extra_done;
    e.tag = tag; e.hi = exp_hi; e.lo = exp_lo;
    sb.push_back(e);
    applyStimulus(ALUOP_FUNCT, 1'b1, SRCB_REG, fn, '0, a_v, b_v, '0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    checkOutput({tag, "_busy_after_start"}, WIDTH'(busy), WIDTH'(1));
    for (int i = 0; i < WIDTH + 8; i++) begin
      if (done) break;
      if (intrude && i == 3)
        applyStimulus(ALUOP_FUNCT, 1'b1, SRCB_REG, FN_DIVU, '0, 32'd1000, 32'd3, '0, 1'b1);
      if (intrude && i == 4) start = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, "_done_seen"}, WIDTH'(done), WIDTH'(1));
    checkOutput({tag, "_done_edge"}, WIDTH'(edges), WIDTH'(WIDTH + 1));
    if (sb.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, WIDTH'(0), WIDTH'(1));
    end else begin
      got = sb.pop_front();
      checkOutput({got.tag, "_hi"}, hi, got.hi);
      checkOutput({got.tag, "_lo"}, lo, got.lo);
    end
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, "_done_one_cycle"}, WIDTH'(done), WIDTH'(0));
    checkOutput({tag, "_idle_after"}, WIDTH'(busy), WIDTH'(0));
    if (intrude) begin
      extra_done = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
        @(posedge clk); #1;
        if (done) extra_done++;
      end
      checkOutput({tag, "_no_second_done"}, WIDTH'(extra_done), WIDTH'(0));
    end
  endtask

  initial begin
    int done_count;
`ifdef ALU_OVERFLOW_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    rst = 1'b1;
    applyStimulus(ALUOP_ADD, 1'b0, SRCB_REG, '0, '0, '0, '0, '0, 1'b0);
    #12;
    checkOutput("rst_alu_out", alu_out, '0);
    checkOutput("rst_hi", hi, '0);
    checkOutput("rst_lo", lo, '0);
    checkOutput("rst_busy", WIDTH'(busy), '0);
    checkOutput("rst_done", WIDTH'(done), '0);
    @(negedge clk);
    rst = 1'b0;

    // Basic ALU paths
    applyStimulus(ALUOP_FUNCT, 1'b1, SRCB_REG, FN_ADD, '0, 32'd5, 32'd7, '0, 1'b0);
    #1;
    checkOutput("add_result", result, 32'd12);
    checkOutput("add_zero", WIDTH'(zero), '0);
    @(posedge clk); #1;
    checkOutput("add_alu_out", alu_out, 32'd12);

    applyStimulus(ALUOP_SUB, 1'b1, SRCB_REG, '0, '0, 32'h1234, 32'h1234, '0, 1'b0);
    #1;
    checkOutput("sub_eq_result", result, '0);
    checkOutput("sub_eq_zero", WIDTH'(zero), WIDTH'(1));

    applyStimulus(ALUOP_ADD, 1'b0, SRCB_IMM_SH2, '0, 32'h100, '0, '0, 16'hFFFF, 1'b0);
    #1;
    checkOutput("pc_imm_sh2", result, 32'hFC);
    applyStimulus(ALUOP_ADD, 1'b0, SRCB_FOUR, '0, 32'h100, '0, '0, '0, 1'b0);
    #1;
    checkOutput("pc_plus4", result, 32'h104);
    applyStimulus(ALUOP_SUB, 1'b1, SRCB_IMM, '0, '0, 32'd10, '0, 16'hFFFE, 1'b0);
    #1;
    checkOutput("sub_imm", result, 32'd12);

    // Logic / compare decode
    applyStimulus(ALUOP_FUNCT, 1'b1, SRCB_REG, FN_AND, '0, 32'hFFFF0000, 32'h0000FFFF, '0, 1'b0);
    #1;
    checkOutput("and_result", result, '0);
    checkOutput("and_zero", WIDTH'(zero), WIDTH'(1));
    funct = FN_OR;   #1; checkOutput("or_result", result, 32'hFFFFFFFF);
    funct = FN_NOR;  #1; checkOutput("nor_result", result, '0);
    funct = FN_SLT;  #1; checkOutput("slt_result", result, 32'd1);
    funct = FN_SLTU; #1; checkOutput("sltu_result", result, '0);
    funct = 6'b111111; #1; checkOutput("bad_funct", result, '0);
    alu_op = ALUOP_SLT; #1; checkOutput("aluop_slt", result, 32'd1);

    // Overflow boundaries
    applyStimulus(ALUOP_ADD, 1'b1, SRCB_REG, '0, '0, 32'h7FFFFFFF, 32'd1, '0, 1'b0);
    #1;
    checkOutput("ovf_add_result", result, 32'h80000000);
    checkOutput("ovf_add", WIDTH'(overflow), WIDTH'(exp_ovf));
    applyStimulus(ALUOP_FUNCT, 1'b1, SRCB_REG, FN_SUB, '0, 32'h80000000, 32'd1, '0, 1'b0);
    #1;
    checkOutput("ovf_sub_result", result, 32'h7FFFFFFF);
    checkOutput("ovf_sub", WIDTH'(overflow), WIDTH'(exp_ovf));
    applyStimulus(ALUOP_ADD, 1'b1, SRCB_REG, '0, '0, 32'd1, 32'd1, '0, 1'b0);
    #1;
    checkOutput("no_ovf_add", WIDTH'(overflow), '0);

    // Multiply / divide through the scoreboard
    runMulDiv("mult_neg", FN_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    applyStimulus(ALUOP_FUNCT, 1'b1, SRCB_REG, FN_MFLO, '0, '0, '0, '0, 1'b0);
    #1; checkOutput("mflo", result, 32'hFFFFFFEB);
    funct = FN_MFHI;
    #1; checkOutput("mfhi", result, 32'hFFFFFFFF);
    runMulDiv("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    runMulDiv("divu_100_7", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    runMulDiv("div_m7_2", FN_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runMulDiv("div_by_zero", FN_DIV, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b0);

    // start with a non-muldiv funct must not launch anything
    applyStimulus(ALUOP_FUNCT, 1'b1, SRCB_REG, FN_ADD, '0, 32'd3, 32'd4, '0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("bad_start_busy", WIDTH'(busy), '0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bad_start_hi", hi, 32'd9);
    checkOutput("bad_start_lo", lo, 32'hFFFFFFFF);

    runMulDiv("mult_intrude", FN_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);

    // Reset on the 10th CALC cycle; mflo mid-operation returns the old lo
    applyStimulus(ALUOP_FUNCT, 1'b1, SRCB_REG, FN_MULTU, '0, 32'd123, 32'd456, '0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    funct = FN_MFLO;
    #1;
    checkOutput("mflo_during_busy", result, 32'd42);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("pre_rst_busy", WIDTH'(busy), WIDTH'(1));
    rst = 1'b1;
    #1;
    checkOutput("midop_rst_busy", WIDTH'(busy), '0);
    checkOutput("midop_rst_hi", hi, '0);
    checkOutput("midop_rst_lo", lo, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_count = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk); #1;
      if (done) done_count++;
    end
    checkOutput("midop_rst_no_done", WIDTH'(done_count), '0);
    checkOutput("scoreboard_drained", WIDTH'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
